ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_ram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port word RAM with a registered read port.
// Partial-strobe writes are done as read-modify-write; full-word writes take one RAM cycle.
module ram_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,

  output logic        ram_ena,
  output logic        ram_rw,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,

  // FSM state for checkers: 0 IDLE, 1 RD_ISSUE, 2 RD_RESP, 3 WR, 4 MERGE
  output logic [2:0]  dbg_state
);

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Handshake: a requester holds req (and its we/addr/wdata/wstrb) until it sees a
  // one-cycle ack; req still high in the cycle after ack is taken as a new request.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_RESP  = 3'd2,
    WR       = 3'd3,
    MERGE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q;
  logic        last_m1_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  logic        any_req;
  logic        pick_m1;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic [31:0] merged;
  logic        ack_int;
  logic        ena_int;

  assign any_req = m0_req | m1_req;
  // Round-robin hands a contended slot to whoever did not win last time.
  assign pick_m1 = m1_req & (~m0_req | ((FAIR != 0) & ~last_m1_q));

  assign sel_we    = pick_m1 ? m1_we    : m0_we;
  assign sel_addr  = pick_m1 ? m1_addr  : m0_addr;
  assign sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
  assign sel_wstrb = pick_m1 ? m1_wstrb : m0_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_m1_q  <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      m0_rdata_q <= 32'h0;
      m1_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      m0_rdata_q <= m0_rdata;
      m1_rdata_q <= m1_rdata;
      if (state_q == IDLE && any_req) begin
        grant_q   <= pick_m1;
        last_m1_q <= pick_m1;
        we_q      <= sel_we;
        addr_q    <= sel_addr & 32'hFFFF_FFFC;
        wdata_q   <= sel_wdata;
        wstrb_q   <= sel_wstrb;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (sel_we && (sel_wstrb == 4'hF || sel_wstrb == 4'h0)) state_d = WR;
          else                                                    state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = we_q ? MERGE : RD_RESP;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    merged = ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    ena_int   = 1'b0;
    ram_rw    = MEM_READ;
    ack_int   = 1'b0;
    ram_wdata = wdata_q;
    case (state_q)
      RD_ISSUE: ena_int = 1'b1;
      RD_RESP:  ack_int = 1'b1;
      WR: begin
        // A zero-strobe write completes without touching the RAM.
        ena_int = (wstrb_q != 4'h0);
        ram_rw  = MEM_WRITE;
        ack_int = 1'b1;
      end
      MERGE: begin
        ena_int   = 1'b1;
        ram_rw    = MEM_WRITE;
        ram_wdata = merged;
        ack_int   = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset kills an in-flight access immediately, not at the next edge.
  assign ram_ena  = ena_int & ~rst;
  assign m0_ack   = ack_int & ~grant_q & ~rst;
  assign m1_ack   = ack_int &  grant_q & ~rst;
  assign ram_addr = addr_q;

  assign m0_rdata = (state_q == RD_RESP && !grant_q) ? ram_rdata : m0_rdata_q;
  assign m1_rdata = (state_q == RD_RESP &&  grant_q) ? ram_rdata : m1_rdata_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: word-RAM model, shadow-memory reference model, per-requester
// expected queues drained by a negedge monitor, plus directed latency/arbitration cases.
module tb_ram_arbiter;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  logic clk = 1'b0;
  logic rst;
  logic preload;

  logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        ram_ena, ram_rw;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [2:0]  dbg_state;

  logic        fp_m0_req, fp_m0_we, fp_m0_ack, fp_m1_req, fp_m1_we, fp_m1_ack;
  logic [31:0] fp_m0_addr, fp_m0_wdata, fp_m0_rdata, fp_m1_addr, fp_m1_wdata, fp_m1_rdata;
  logic [3:0]  fp_m0_wstrb, fp_m1_wstrb;
  logic        fp_ram_ena, fp_ram_rw;
  logic [31:0] fp_ram_addr, fp_ram_wdata;
  logic [31:0] fp_ram_rdata;
  logic [2:0]  fp_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [63:0] wr_q0[$];
  logic [63:0] wr_q1[$];
  logic [31:0] shadow[32];
  int          grant_log[$];
  logic [31:0] mem[32];

  always #5 clk = ~clk;

  ram_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_ena(ram_ena), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  ram_arbiter #(.FAIR(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(fp_m0_req), .m0_we(fp_m0_we), .m0_addr(fp_m0_addr), .m0_wdata(fp_m0_wdata),
    .m0_wstrb(fp_m0_wstrb), .m0_ack(fp_m0_ack), .m0_rdata(fp_m0_rdata),
    .m1_req(fp_m1_req), .m1_we(fp_m1_we), .m1_addr(fp_m1_addr), .m1_wdata(fp_m1_wdata),
    .m1_wstrb(fp_m1_wstrb), .m1_ack(fp_m1_ack), .m1_rdata(fp_m1_rdata),
    .ram_ena(fp_ram_ena), .ram_rw(fp_ram_rw), .ram_addr(fp_ram_addr), .ram_wdata(fp_ram_wdata),
    .ram_rdata(fp_ram_rdata), .dbg_state(fp_dbg_state)
  );

  assign fp_ram_rdata = 32'hCAFE_F00D;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)  return 32'hDEAD_BEEF;
    if (i == 20) return 32'h1122_3344;
    return (32'h0101_0101 * i) ^ 32'hA5A5_0000;
  endfunction

  // Word RAM with registered read data; words 0..15 belong to m0, 16..31 to m1.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (ram_ena && ram_rw == MEM_WRITE) begin
      mem[ram_addr[6:2]] <= ram_wdata;
    end else if (ram_ena) begin
      ram_rdata <= mem[ram_addr[6:2]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: reads return the shadow word, writes merge by strobe lanes.
  task automatic issue(input int m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] w;
    int idx;
    idx = int'(addr[6:2]);
    if (!we) begin
      if (m == 0) exp_q0.push_back({1'b1, shadow[idx]});
      else        exp_q1.push_back({1'b1, shadow[idx]});
    end else begin
      w = shadow[idx];
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      if (m == 0) exp_q0.push_back({1'b0, 32'h0});
      else        exp_q1.push_back({1'b0, 32'h0});
      if (strb != 4'h0) begin
        shadow[idx] = w;
        if (m == 0) wr_q0.push_back({addr & 32'hFFFF_FFFC, w});
        else        wr_q1.push_back({addr & 32'hFFFF_FFFC, w});
      end
    end
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wstrb = strb;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wstrb = strb;
    end
  endtask

  task automatic wait_ack(input int m, input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
        lat = c;
        break;
      end
    end
    chk((m == 0) ? "m0_ack_in_budget" : "m1_ack_in_budget", 64'(lat > 0), 64'd1);
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    logic [63:0] w;
    if (m0_ack || m1_ack) chk("ack_exclusive", 64'(m0_ack & m1_ack), 64'd0);
    if (m0_ack) begin
      grant_log.push_back(0);
      if (exp_q0.size() == 0) chk("m0_ack_unexpected", 64'(m0_ack), 64'd0);
      else begin
        e = exp_q0.pop_front();
        if (e[32]) chk("m0_rdata", 64'(m0_rdata), 64'(e[31:0]));
      end
    end
    if (m1_ack) begin
      grant_log.push_back(1);
      if (exp_q1.size() == 0) chk("m1_ack_unexpected", 64'(m1_ack), 64'd0);
      else begin
        e = exp_q1.pop_front();
        if (e[32]) chk("m1_rdata", 64'(m1_rdata), 64'(e[31:0]));
      end
    end
    if (ram_ena && ram_rw == MEM_WRITE) begin
      if (!ram_addr[6]) begin
        if (wr_q0.size() == 0) chk("ram_write_unexpected", 64'(ram_ena), 64'd0);
        else begin w = wr_q0.pop_front(); chk("ram_write_m0", {ram_addr, ram_wdata}, w); end
      end else begin
        if (wr_q1.size() == 0) chk("ram_write_unexpected", 64'(ram_ena), 64'd0);
        else begin w = wr_q1.pop_front(); chk("ram_write_m1", {ram_addr, ram_wdata}, w); end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic random_traffic(input int m, input int n);
    int lat, gap, sel;
    logic we;
    logic [3:0]  strb;
    logic [31:0] addr;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      we   = 1'($urandom_range(0, 1));
      sel  = $urandom_range(0, 3);
      strb = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(1, 14));
      addr = 32'((m * 16 + $urandom_range(0, 15)) * 4 + $urandom_range(0, 3));
      issue(m, we, addr, $urandom, strb);
      wait_ack(m, 20, lat);
      @(posedge clk); #1;
    end
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt;
    rst = 1'b1; preload = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    fp_m0_req = 0; fp_m0_we = 0; fp_m0_addr = 0; fp_m0_wdata = 0; fp_m0_wstrb = 0;
    fp_m1_req = 0; fp_m1_we = 0; fp_m1_addr = 0; fp_m1_wdata = 0; fp_m1_wstrb = 0;
    for (int i = 0; i < 32; i++) shadow[i] = init_word(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_ena", 64'(ram_ena), 64'd0);
    chk("rst_ram_rw", 64'(ram_rw), 64'(MEM_READ));
    chk("rst_acks", {m0_ack, m1_ack}, 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; preload = 1'b0;

    // Single read of a preloaded word.
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    @(negedge clk); chk("rd_T_ena", 64'(ram_ena), 64'd0);
    @(negedge clk); chk("rd_T1_ena_rw_ack", {ram_ena, ram_rw, m0_ack}, {1'b1, MEM_READ, 1'b0});
    chk("rd_T1_addr", 64'(ram_addr), 64'h10);
    @(negedge clk); chk("rd_T2_ack", 64'(m0_ack), 64'd1);
    chk("rd_T2_rdata", 64'(m0_rdata), 64'hDEAD_BEEF);
    @(posedge clk); #1 m0_req = 1'b0;

    // Byte write with a misaligned address: read-modify-write of 0x11223344.
    issue(1, 1'b1, 32'h0000_0051, 32'h0000_AB00, 4'b0010);
    @(negedge clk);
    @(negedge clk); chk("bw_T1_ena_rw", {ram_ena, ram_rw}, {1'b1, MEM_READ});
    chk("bw_T1_addr", 64'(ram_addr), 64'h50);
    @(negedge clk); chk("bw_T2_ena_rw_ack", {ram_ena, ram_rw, m1_ack}, {1'b1, MEM_WRITE, 1'b1});
    chk("bw_T2_wdata", 64'(ram_wdata), 64'h1122_AB44);
    @(posedge clk); #1 m1_req = 1'b0;

    // Zero-strobe write: ack after one cycle, RAM untouched.
    issue(0, 1'b1, 32'h0000_0018, 32'h1234_5678, 4'h0);
    @(negedge clk); chk("zw_T_ena", 64'(ram_ena), 64'd0);
    @(negedge clk); chk("zw_T1_ack_ena", {m0_ack, ram_ena}, {1'b1, 1'b0});
    @(posedge clk); #1 m0_req = 1'b0;
    issue(0, 1'b0, 32'h0000_0018, 32'h0, 4'h0);
    wait_ack(0, 6, lat);
    chk("zw_readback_latency", 64'(lat), 64'd3);
    @(posedge clk); #1 m0_req = 1'b0;

    // Reset lands in the RD_ISSUE cycle of a partial write: nothing may be written.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h14; m0_wdata = 32'h0000_00FF; m0_wstrb = 4'b0001;
    @(posedge clk); #1;
    rst = 1'b1; m0_req = 1'b0;
    @(negedge clk); chk("rmw_rst_ena_ack", {ram_ena, m0_ack}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("rmw_rst_state", 64'(dbg_state), 64'd0);
    chk("rmw_rst_idle_ena", 64'(ram_ena), 64'd0);
    @(posedge clk); #1;
    issue(0, 1'b0, 32'h0000_0014, 32'h0, 4'h0);
    wait_ack(0, 6, lat);
    @(posedge clk); #1 m0_req = 1'b0;

    // Round-robin: both requesters stream two full-word writes each.
    do_reset();
    grant_log.delete();
    fork
      for (int k = 0; k < 2; k++) begin
        int l0;
        issue(0, 1'b1, 32'(4 * k + 32), $urandom, 4'hF);
        wait_ack(0, 10, l0);
        @(posedge clk); #1;
      end
      for (int k = 0; k < 2; k++) begin
        int l1;
        issue(1, 1'b1, 32'(4 * k + 96), $urandom, 4'hF);
        wait_ack(1, 10, l1);
        @(posedge clk); #1;
      end
    join
    m0_req = 1'b0; m1_req = 1'b0;
    chk("rr_grant_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) chk("rr_grant_order", 64'(grant_log[k]), 64'(k % 2));

    // Fixed priority: m1 starves while m0 keeps requesting.
    fp_m0_req = 1'b1; fp_m0_addr = 32'h0;
    fp_m1_req = 1'b1; fp_m1_addr = 32'h4;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fp_m0_ack) cnt++;
      chk("fp_m1_starved", 64'(fp_m1_ack), 64'd0);
    end
    chk("fp_m0_ack_count", 64'(cnt), 64'd3);
    @(posedge clk); #1 fp_m0_req = 1'b0;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (fp_m1_ack) begin
        lat = c;
        chk("fp_m1_rdata", 64'(fp_m1_rdata), 64'hCAFE_F00D);
        break;
      end
    end
    chk("fp_m1_served", 64'(lat > 0), 64'd1);
    @(posedge clk); #1 fp_m1_req = 1'b0;

    // Random concurrent traffic on disjoint halves of the RAM.
    fork
      random_traffic(0, 60);
      random_traffic(1, 60);
    join
    repeat (4) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    chk("wr_q_drained", 64'(wr_q0.size() + wr_q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
